sync_fifo: RTL and testbench

Single-clock, parametrised FIFO buffer; the synchronous successor to the team's asynchronous FIFO for paths where producer and consumer share one clock. Adds configurable depth/width, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Optional first-word-fall-through (FWFT) read mode is selected at compile time.

---
 rtl/sync_fifo.sv | 115 +++++++++++
 tb/tb_sync_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage has no reset; a write presented during reset must not land.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Status flags are derived from the next count so they never lag count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == LP_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= LP_AFULL);
      r_aempty <= (w_count_nxt <= LP_AEMPTY);
      if (wr_en && r_full)  r_ovf <= 1'b1;
      else if (err_clr)     r_ovf <= 1'b0;
      if (rd_en && r_empty) r_udf <= 1'b1;
      else if (err_clr)     r_udf <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign dout = r_dout;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (16 x 8, thresholds 12/2).
// Covers both standard and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (4),
    .AFULL_THRESH (12),
    .AEMPTY_THRESH(2)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .din         (din),
    .rd_en       (rd_en),
    .err_clr     (err_clr),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr_en   = w;
    rd_en   = r;
    din     = d;
    err_clr = c;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic flags(input string tag, input int cnt, input logic ovf, input logic udf);
    check({tag, ".count"}, 32'(count), cnt);
    check({tag, ".empty"}, 32'(empty), (cnt == 0) ? 1 : 0);
    check({tag, ".full"}, 32'(full), (cnt == 16) ? 1 : 0);
    check({tag, ".afull"}, 32'(almost_full), (cnt >= 12) ? 1 : 0);
    check({tag, ".aempty"}, 32'(almost_empty), (cnt <= 2) ? 1 : 0);
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    check({tag, ".udf"}, 32'(underflow), 32'(udf));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;
    step(0, 0, 8'h00, 0);
    rst = 1'b0;
    flags("reset", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("reset.dout", 32'(dout), 0);
`endif

    // Fill past full: words 17..20 are dropped.
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 8'(i), 0);
      flags("fill", (i > 16) ? 16 : i, (i >= 17), 0);
`ifdef SYNC_FIFO_FWFT_EN
      check("fill.head", 32'(dout), 1);
`endif
    end

    // Drain with one extra read.
    for (int k = 1; k <= 17; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      if (k <= 16) check("drain.head", 32'(dout), k);
`endif
      step(0, 1, 8'h00, 0);
      flags("drain", (k >= 16) ? 0 : 16 - k, 1, (k >= 17));
`ifndef SYNC_FIFO_FWFT_EN
      check("drain.dout", 32'(dout), (k <= 16) ? k : 16);
`endif
    end
    step(0, 0, 8'h00, 1);
    flags("errclr", 0, 0, 0);

    // Wrap-around: pointers cross the end of the array.
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int j = 0; j < 10; j++) step(1, 0, 8'(8'h20 + rnd * 10 + j), 0);
      flags("wrap.fill", 10, 0, 0);
      for (int j = 0; j < 10; j++) begin
`ifdef SYNC_FIFO_FWFT_EN
        check("wrap.head", 32'(dout), 32'h20 + rnd * 10 + j);
`endif
        step(0, 1, 8'h00, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("wrap.dout", 32'(dout), 32'h20 + rnd * 10 + j);
`endif
      end
      flags("wrap.drain", 0, 0, 0);
    end

    // Simultaneous read/write while full.
    for (int j = 0; j < 16; j++) step(1, 0, 8'(8'h40 + j), 0);
    flags("sfull.pre", 16, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("sfull.head", 32'(dout), 32'h40);
`endif
    step(1, 1, 8'hAA, 0);
    flags("sfull", 15, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("sfull.dout", 32'(dout), 32'h40);
`endif
    for (int j = 1; j < 16; j++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("sfull.drain.head", 32'(dout), 32'h40 + j);
`endif
      step(0, 1, 8'h00, 0);
`ifndef SYNC_FIFO_FWFT_EN
      check("sfull.drain.dout", 32'(dout), 32'h40 + j);
`endif
    end
    step(0, 0, 8'h00, 1);
    flags("sfull.clr", 0, 0, 0);

    // Simultaneous read/write while empty.
    step(1, 1, 8'h5A, 0);
    flags("sempty", 1, 0, 1);
`ifdef SYNC_FIFO_FWFT_EN
    check("sempty.head", 32'(dout), 32'h5A);
`endif
    step(0, 1, 8'h00, 1);
    flags("sempty.rd", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("sempty.dout", 32'(dout), 32'h5A);
`endif

    // Streaming at full throughput with four words in flight.
    for (int j = 0; j < 4; j++) step(1, 0, 8'(8'h60 + j), 0);
    for (int k = 0; k < 50; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("stream.head", 32'(dout), 32'(8'(8'h60 + k)));
`endif
      step(1, 1, 8'(8'h64 + k), 0);
`ifndef SYNC_FIFO_FWFT_EN
      check("stream.dout", 32'(dout), 32'(8'(8'h60 + k)));
`endif
      check("stream.count", 32'(count), 4);
    end
    flags("stream.end", 4, 0, 0);
    for (int j = 0; j < 4; j++) step(0, 1, 8'h00, 0);
    flags("stream.drain", 0, 0, 0);

    // Reset mid-operation with a write in the reset cycle.
    step(0, 1, 8'h00, 0);
    flags("rst.udf", 0, 0, 1);
    for (int j = 0; j < 9; j++) step(1, 0, 8'(8'h70 + j), 0);
    flags("rst.pre", 9, 0, 1);
    rst = 1'b1;
    step(1, 0, 8'h99, 0);
    rst = 1'b0;
    flags("rst.post", 0, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst.dout", 32'(dout), 0);
`endif
    step(1, 0, 8'h11, 0);
    flags("rst.wr", 1, 0, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("rst.head", 32'(dout), 32'h11);
`endif
    step(0, 1, 8'h00, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst.rd.dout", 32'(dout), 32'h11);
`endif
    flags("rst.rd", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
